// File: rtl/signed_mult_seq.sv
// Sequential radix-2 multiplier: Booth recoding for two's-complement operands,
// shift-add for unsigned ones. Define SIGNED_MULT_SEQ_OVF_EN to add the ovf output.
module signed_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod_out,
`ifdef SIGNED_MULT_SEQ_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // One guard bit on the accumulator lets Booth subtract the most-negative value
  // and lets shift-add keep its carry.
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic             booth_bit, booth_bit_next;
  logic             mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             last_iter;

  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  always_comb begin
    sum      = acc;
    acc_next = acc;
    if (mode) begin
      case ({mplier[0], booth_bit})
        2'b01:   sum = acc + mcand;
        2'b10:   sum = acc - mcand;
        default: sum = acc;
      endcase
      acc_next = {sum[WIDTH], sum[WIDTH:1]};
    end else begin
      if (mplier[0]) sum = acc + mcand;
      acc_next = {1'b0, sum[WIDTH:1]};
    end
    mplier_next    = {sum[0], mplier[WIDTH-1:1]};
    booth_bit_next = mplier[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      booth_bit <= 1'b0;
      mode      <= 1'b0;
      cnt       <= '0;
      prod_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand     <= {a_in[WIDTH-1] & signed_mode, a_in};
            mplier    <= b_in;
            booth_bit <= 1'b0;
            acc       <= '0;
            mode      <= signed_mode;
            cnt       <= CW'(WIDTH);
          end
        end
        BUSY: begin
          acc       <= acc_next;
          mplier    <= mplier_next;
          booth_bit <= booth_bit_next;
          cnt       <= cnt - CW'(1);
          if (last_iter) prod_out <= {acc_next[WIDTH-1:0], mplier_next};
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_MULT_SEQ_OVF_EN
  // Signed fit: top WIDTH+1 bits all equal; unsigned fit: top WIDTH bits zero.
  logic ovf_cond;

  always_comb begin
    ovf_cond = 1'b0;
    if (mode)
      ovf_cond = ~((&prod_out[2*WIDTH-1:WIDTH-1]) | ~(|prod_out[2*WIDTH-1:WIDTH-1]));
    else
      ovf_cond = |prod_out[2*WIDTH-1:WIDTH];
  end

  assign ovf = (state == DONE) && ovf_cond;
`endif

endmodule

// File: tb/tb_signed_mult_seq.sv
// Self-checking bench for signed_mult_seq (WIDTH=8): vector table, corner-case
// sequences and a back-to-back random run, all checked through a scoreboard queue.
module tb_signed_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           signed_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] prod_out;
  logic           busy;
`ifdef SIGNED_MULT_SEQ_OVF_EN
  logic           ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           m;
    logic [2*W-1:0] prod;
    logic           ovf;
  } vec_t;

  exp_t expQ[$];

  signed_mult_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .prod_out    (prod_out),
`ifdef SIGNED_MULT_SEQ_OVF_EN
    .ovf         (ovf),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int x, y, p;
    exp_t e;
    x = m ? int'($signed(a)) : int'(a);
    y = m ? int'($signed(b)) : int'(b);
    p = x * y;
    e.prod = p[2*W-1:0];
    e.ovf  = m ? (p > 127 || p < -128) : (p > 255);
    return e;
  endfunction

  // Scoreboard: a transfer happens at the next rising edge whenever both
  // handshake signals are high here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h, expected no output at %0t", prod_out, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("product", 32'(prod_out), 32'(e.prod));
`ifdef SIGNED_MULT_SEQ_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                               input exp_t e);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'(1));
    a_in = a; b_in = b; signed_mode = m; in_valid = 1'b1;
    expQ.push_back(e);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    a_in        = W'($urandom);
    b_in        = W'($urandom);
    signed_mode = 1'($urandom);
    checkOutput("busy_after_accept", 32'({busy, in_ready}), 32'(2'b10));
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput(name, 32'(expQ.size()), 32'(0));
    expQ.delete();
  endtask

  task automatic measureLatency(input string name);
    int lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput(name, 32'(lat), 32'(W));
  endtask

  vec_t vecs[15];

  initial begin
    int cyc, last, accepted;
    logic [W-1:0] ca, cb;
    logic cm;

    vecs[0]  = '{8'h05, 8'h03, 1'b1, 16'h000F, 1'b0};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1};
    vecs[2]  = '{8'h80, 8'h80, 1'b0, 16'h4000, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0};
    vecs[5]  = '{8'hF9, 8'h06, 1'b1, 16'hFFD6, 1'b0};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b1};
    vecs[7]  = '{8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1};
    vecs[9]  = '{8'h0F, 8'h11, 1'b0, 16'h00FF, 1'b0};
    vecs[10] = '{8'h10, 8'h10, 1'b0, 16'h0100, 1'b1};
    vecs[11] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, 1'b0};
    vecs[12] = '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0};
    vecs[13] = '{8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1};
    vecs[14] = '{8'h80, 8'hFF, 1'b0, 16'h7F80, 1'b1};

    // Asynchronous reset: outputs must clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_in_ready",  32'(in_ready),  32'(1));
    checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_busy",      32'(busy),      32'(0));
    checkOutput("reset_prod",      32'(prod_out),  32'(0));
`ifdef SIGNED_MULT_SEQ_OVF_EN
    checkOutput("reset_ovf",       32'(ovf),       32'(0));
`endif
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // First operation with latency measurement.
    out_ready = 1'b1;
    applyStimulus(8'h05, 8'h03, 1'b1, '{16'h000F, 1'b0});
    measureLatency("latency_first");
    drain("drain_first");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].m, '{vecs[i].prod, vecs[i].ovf});
      drain($sformatf("drain_vec%0d", i));
    end

    // Consumer stalls for 20 cycles; stray in_valid pulses must be ignored.
    out_ready = 1'b0;
    applyStimulus(8'hF9, 8'h06, 1'b1, '{16'hFFD6, 1'b0});
    measureLatency("latency_hold");
    for (int i = 0; i < 20; i++) begin
      checkOutput("hold_out_valid", 32'(out_valid), 32'(1));
      checkOutput("hold_prod",      32'(prod_out),  32'(16'hFFD6));
      checkOutput("hold_in_ready",  32'(in_ready),  32'(0));
      in_valid = (i % 2 == 0);
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_hold");
    checkOutput("idle_after_hold", 32'({in_ready, busy, out_valid}), 32'(3'b100));
    checkOutput("idle_prod_kept",  32'(prod_out), 32'(16'hFFD6));
`ifdef SIGNED_MULT_SEQ_OVF_EN
    checkOutput("idle_ovf_low",    32'(ovf), 32'(0));
`endif

    // Reset during the fourth BUSY cycle discards the operation.
    applyStimulus(8'h33, 8'h44, 1'b0, '{16'h0D8C, 1'b1});
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    expQ.delete();
    checkOutput("midreset_state", 32'({in_ready, busy, out_valid}), 32'(3'b100));
    checkOutput("midreset_prod",  32'(prod_out), 32'(0));
    a_in = 8'h02; b_in = 8'h02; signed_mode = 1'b1; in_valid = 1'b1;
    expQ.push_back('{16'h0004, 1'b0});
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("first_accept_after_reset", 32'(busy), 32'(1));
    measureLatency("latency_after_reset");
    drain("drain_after_reset");

    // Back-to-back random traffic with in_valid held high.
    last = -1; accepted = 0; cyc = 0;
    ca = W'($urandom); cb = W'($urandom); cm = 1'($urandom);
    a_in = ca; b_in = cb; signed_mode = cm; in_valid = 1'b1;
    while (accepted < 1000 && cyc < 20000) begin
      logic will_accept;
      will_accept = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_accept) begin
        expQ.push_back(model(ca, cb, cm));
        accepted++;
        if (last >= 0) checkOutput("b2b_period", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        ca = W'($urandom); cb = W'($urandom); cm = 1'($urandom);
        a_in = ca; b_in = cb; signed_mode = cm;
        if (accepted == 1000) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_accept_count", 32'(accepted), 32'(1000));
    drain("drain_b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
